// File: rtl/binary_to_bcd_converter_if.sv
// binary_to_bcd_converter_if
//   Handshake and data bundle for the sequential binary-to-BCD converter.
//   W: binary width, D: number of BCD digits.
//   start_i  : request a conversion (driven by the master)
//   binary_i : unsigned value captured on the accepted start edge
//   ready_o  : converter is idle and will accept start_i
//   done_o   : one-cycle pulse, bcd_o holds a fresh result
//   bcd_o    : packed BCD result, digit 0 in bits [3:0]
interface binary_to_bcd_converter_if #(
  parameter int W = 16,
  parameter int D = 5
);
  logic           start_i;
  logic [W-1:0]   binary_i;
  logic           ready_o;
  logic           done_o;
  logic [4*D-1:0] bcd_o;

  modport master (
    output start_i,
    output binary_i,
    input  ready_o,
    input  done_o,
    input  bcd_o
  );

  modport slave (
    input  start_i,
    input  binary_i,
    output ready_o,
    output done_o,
    output bcd_o
  );
endinterface

// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter
//   Sequential double-dabble (shift-and-add-3) converter: one iteration per
//   input bit, W OP cycles per conversion, followed by a one-cycle DONE.
//   clk_i   : clock, all state updates on the rising edge
//   reset_i : synchronous, active-high reset
//   bus     : slave side of binary_to_bcd_converter_if (start/binary in,
//             ready/done/bcd out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready_o high, waits for start_i, captures binary_i
//   OP    | one adjust+shift iteration per cycle, W cycles in total
//   DONE  | done_o high for one cycle, bcd_o holds the new result
module binary_to_bcd_converter #(
  parameter int W = 16,
  parameter int D = 5
) (
  input logic                         clk_i,
  input logic                         reset_i,
  binary_to_bcd_converter_if.slave    bus
);

  localparam int CW = $clog2(W) + 1;
  localparam int BW = 4 * D;

  // True when D digits can represent 2^W-1. The running power of ten stops
  // growing once it passes the maximum, so it never overflows 64 bits.
  function automatic bit digits_fit();
    longint unsigned max_val;
    longint unsigned p;
    max_val = (64'd1 << W) - 64'd1;
    p = 64'd1;
    for (int i = 0; i < D; i++) begin
      if (p <= max_val) p = p * 64'd10;
    end
    return (p > max_val);
  endfunction

  if (W < 1 || W > 32) begin : g_bad_width
    $error("binary_to_bcd_converter: W must be within 1..32");
  end
  if (!digits_fit()) begin : g_bad_digits
    $error("binary_to_bcd_converter: 10^D must exceed 2^W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   bcd_work;
  logic [W-1:0]    bin_shift;
  logic [CW-1:0]   iter_cnt;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_next;

  // Add-3 correction applied to every digit in parallel before the shift,
  // so a digit of 5..9 carries correctly into the next digit after doubling.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < D; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Working BCD value after this iteration's shift; the MSB of the binary
  // shift register enters at the bottom.
  assign bcd_next = {bcd_adj[BW-2:0], bin_shift[W-1]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      bcd_work  <= '0;
      bin_shift <= '0;
      iter_cnt  <= '0;
      bcd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            bin_shift <= bus.binary_i;
            bcd_work  <= '0;
            iter_cnt  <= CW'(W - 1);
            state     <= OP;
          end
        end
        OP: begin
          bcd_work  <= bcd_next;
          bin_shift <= bin_shift << 1;
          if (iter_cnt == '0) begin
            bcd_q <= bcd_next;
            state <= DONE;
          end else begin
            iter_cnt <= iter_cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded from the state register alone, so no path exists from
  // start_i or binary_i to ready_o/done_o.
  assign bus.ready_o = (state == IDLE);
  assign bus.done_o  = (state == DONE);
  assign bus.bcd_o   = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
module tb_binary_to_bcd_converter;
  localparam int W = 16;
  localparam int D = 5;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;

  binary_to_bcd_converter_if #(.W(W), .D(D)) bus ();

  binary_to_bcd_converter #(.W(W), .D(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Decimal digits of v, digit 0 least significant.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reads a packed BCD word back as a number (the BCD-to-binary direction).
  function automatic longint unsigned from_bcd(input logic [19:0] b);
    longint unsigned r;
    longint unsigned m;
    r = 0;
    m = 1;
    for (int i = 0; i < D; i++) begin
      r = r + longint'(b[4*i +: 4]) * m;
      m = m * 10;
    end
    return r;
  endfunction

  // Timing model: a conversion accepted at edge k occupies W+1 cycles before
  // returning to idle, the last of them being the done cycle.
  int          m_busy = 0;
  int unsigned m_val  = 0;
  logic [19:0] m_bcd  = '0;
  bit          m_live = 1'b0;

  always @(posedge clk_i) begin
    cyc++;
    m_live = 1'b1;
    if (reset_i) begin
      m_busy = 0;
      m_bcd  = '0;
    end else if (m_busy == 0) begin
      if (bus.start_i) begin
        m_busy = W + 1;
        m_val  = int'(bus.binary_i);
      end
    end else begin
      m_busy--;
      if (m_busy == 1) m_bcd = to_bcd(m_val);
    end
  end

  always @(negedge clk_i) begin
    if (m_live) begin
      check("ready_o", bus.ready_o, (m_busy == 0));
      check("done_o",  bus.done_o,  (m_busy == 1));
      check("bcd_o",   bus.bcd_o,   m_bcd);
    end
  end

  int done_count = 0;
  always @(negedge clk_i) if (bus.done_o) done_count++;

  // Waits for done_o; returns the number of edges since the call.
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i); #1;
      lat++;
      if (bus.done_o === 1'b1) return;
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (bus.ready_o === 1'b1) return;
      @(posedge clk_i); #1;
    end
    check("ready_timeout", 0, 1);
  endtask

  // Single conversion: start accepted at the next edge, checks latency,
  // result literal and the return of ready_o one cycle after done.
  task automatic convert(input string name, input int unsigned v, input logic [19:0] exp);
    int lat;
    wait_ready();
    bus.start_i  = 1'b1;
    bus.binary_i = 16'(v);
    @(posedge clk_i); #1;
    bus.start_i  = 1'b0;
    bus.binary_i = 16'($urandom);
    wait_done(name, lat);
    check({name, "_latency"}, lat, W);
    check({name, "_bcd"}, bus.bcd_o, exp);
    @(posedge clk_i); #1;
    check({name, "_ready_after"}, bus.ready_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t_done [3];
    int unsigned vals [3];
    logic [19:0] exps [3];
    int dc0;
    int unsigned v;

    bus.start_i  = 1'b0;
    bus.binary_i = '0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready", bus.ready_o, 1);
    check("reset_done",  bus.done_o,  0);
    check("reset_bcd",   bus.bcd_o,   0);
    reset_i = 1'b0;

    convert("zero",  0,     20'h00000);
    convert("v1234", 1234,  20'h01234);
    convert("vmax",  65535, 20'h65535);
    convert("v9",    9,     20'h00009);
    convert("v10",   10,    20'h00010);

    // start_i held high: back-to-back conversions every W+2 cycles.
    vals = '{100, 59999, 42};
    exps = '{20'h00100, 20'h59999, 20'h00042};
    wait_ready();
    bus.start_i  = 1'b1;
    bus.binary_i = 16'(vals[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      if (i < 2) bus.binary_i = 16'(vals[i+1]);
      wait_done("b2b", lat);
      t_done[i] = cyc;
      check("b2b_bcd", bus.bcd_o, exps[i]);
      if (i == 2) bus.start_i = 1'b0;
      else @(posedge clk_i); // DONE->IDLE; next edge accepts
    end
    check("b2b_gap1", t_done[1] - t_done[0], W + 2);
    check("b2b_gap2", t_done[2] - t_done[1], W + 2);

    // start_i during OP is ignored.
    wait_ready();
    dc0 = done_count;
    bus.start_i  = 1'b1;
    bus.binary_i = 16'd500;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    bus.start_i  = 1'b1;
    bus.binary_i = 16'd777;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    wait_done("ign", lat);
    check("ign_bcd", bus.bcd_o, 20'h00500);
    repeat (25) @(posedge clk_i);
    #1;
    check("ign_done_pulses", done_count - dc0, 1);

    // Reset on the 8th OP cycle aborts the conversion.
    wait_ready();
    bus.start_i  = 1'b1;
    bus.binary_i = 16'd4321;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #1;
    check("abort_in_op", bus.ready_o, 0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check("abort_bcd",   bus.bcd_o,   0);
    check("abort_ready", bus.ready_o, 1);
    dc0 = done_count;
    repeat (25) @(posedge clk_i);
    #1;
    check("abort_no_done", done_count - dc0, 0);
    convert("v4321", 4321, 20'h04321);

    // Regression: edge values, powers of 10 and 2, then random values.
    for (int i = 0; i < 2000; i++) begin
      if (i == 0)       v = 0;
      else if (i == 1)  v = 65535;
      else if (i < 7)   v = 10 ** (i - 2);
      else if (i < 23)  v = 1 << (i - 7);
      else              v = $urandom_range(0, 65535);
      wait_ready();
      bus.start_i  = 1'b1;
      bus.binary_i = 16'(v);
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      wait_done("reg", lat);
      check("reg_decimal", from_bcd(bus.bcd_o), v);
    end

    repeat (3) @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
